shift_cmd_sequencer: RTL and testbench

//   Upstream front-end for the registered barrel shifter (1-cycle latency, no valid/ready).
//   - Buffers shift commands arriving on a valid/ready interface.
//   - Issues at most one command per cycle to the shifter and tracks the in-flight slot.
//   - Captures each shifter result into a result FIFO; results leave on valid/ready.
//   - Credit control ensures no result is ever dropped under downstream backpressure.

---
 rtl/shift_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_sequencer.sv
// Front-end for a registered barrel shifter: queues commands, issues one per cycle
// under result-FIFO credit, captures the shifter output one cycle later, emits results in order.
module shift_cmd_sequencer #(
    parameter int BUSWIDTH   = 32,
    parameter int SHIFTWIDTH = 5,
    parameter int CMD_DEPTH  = 4,
    parameter int RES_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [BUSWIDTH-1:0]   cmd_data,
    input  logic                  cmd_rotation,
    input  logic                  cmd_direction,
    input  logic [SHIFTWIDTH-1:0] cmd_shift_val,
    output logic [BUSWIDTH-1:0]   sh_data_in,
    output logic                  sh_rotation,
    output logic                  sh_direction,
    output logic [SHIFTWIDTH-1:0] sh_shift_val,
    input  logic [BUSWIDTH-1:0]   sh_data_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [BUSWIDTH-1:0]   res_data,
    output logic                  busy
);

    localparam int CMD_W = BUSWIDTH + 2 + SHIFTWIDTH;
    localparam int CAW   = $clog2(CMD_DEPTH);
    localparam int CCW   = CAW + 1;
    localparam int RAW   = $clog2(RES_DEPTH);
    localparam int RCW   = RAW + 1;

    localparam logic [CCW-1:0] CMD_FULL_CNT = CCW'(CMD_DEPTH);
    localparam logic [RCW-1:0] RES_FULL_CNT = RCW'(RES_DEPTH);
    localparam logic [RCW:0]   RES_LIMIT    = (RCW + 1)'(RES_DEPTH);

    // command FIFO
    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]   cmd_wr_ptr;
    logic [CAW-1:0]   cmd_rd_ptr;
    logic [CCW-1:0]   cmd_count;
    logic             cmd_full;
    logic             cmd_empty;
    logic             cmd_push;
    logic             cmd_pop;
    logic [CMD_W-1:0] cmd_wdata;
    logic [CMD_W-1:0] cmd_head;

    // result FIFO
    logic [BUSWIDTH-1:0] res_mem [RES_DEPTH];
    logic [RAW-1:0]      res_wr_ptr;
    logic [RAW-1:0]      res_rd_ptr;
    logic [RCW-1:0]      res_count;
    logic                res_full;
    logic                res_empty;
    logic                res_push;
    logic                res_pop;

    // issue / credit
    logic           inflight;
    logic           issue;
    logic [RCW-1:0] res_count_net;
    logic [RCW:0]   credit_used;

    assign cmd_full  = (cmd_count == CMD_FULL_CNT);
    assign cmd_empty = (cmd_count == '0);
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;
    assign cmd_pop   = issue;
    assign cmd_wdata = {cmd_data, cmd_rotation, cmd_direction, cmd_shift_val};
    assign cmd_head  = cmd_mem[cmd_rd_ptr];

    assign res_full  = (res_count == RES_FULL_CNT);
    assign res_empty = (res_count == '0);
    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;
    assign res_push  = inflight && !res_full;
    assign res_data  = res_mem[res_rd_ptr];

    // Credit counts results already held (net of this cycle's pop) plus the one in the shifter.
    assign res_count_net = res_count - {{(RCW-1){1'b0}}, res_pop};
    assign credit_used   = {1'b0, res_count_net} + {{RCW{1'b0}}, inflight};
    assign issue         = !cmd_empty && (credit_used < RES_LIMIT);

    always_comb begin
        {sh_data_in, sh_rotation, sh_direction, sh_shift_val} = '0;
        if (!cmd_empty) begin
            {sh_data_in, sh_rotation, sh_direction, sh_shift_val} = cmd_head;
        end
    end

    assign busy = !cmd_empty || inflight || !res_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cmd_mem[i] <= '0;
            end
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem[cmd_wr_ptr] <= cmd_wdata;
                cmd_wr_ptr          <= cmd_wr_ptr + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            end
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                res_mem[i] <= '0;
            end
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else begin
            if (res_push) begin
                res_mem[res_wr_ptr] <= sh_data_out;
                res_wr_ptr          <= res_wr_ptr + 1'b1;
            end
            if (res_pop) begin
                res_rd_ptr <= res_rd_ptr + 1'b1;
            end
            case ({res_push, res_pop})
                2'b10:   res_count <= res_count + 1'b1;
                2'b01:   res_count <= res_count - 1'b1;
                default: res_count <= res_count;
            endcase
        end
    end

    // A result arriving while the FIFO is full would mean the credit accounting is broken.
    a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight && res_full));

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: models the external registered shifter, drives directed
// commands, and checks results through an expected-value queue.
module tb_shift_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        cmd_rotation;
    logic        cmd_direction;
    logic [4:0]  cmd_shift_val;
    logic [31:0] sh_data_in;
    logic        sh_rotation;
    logic        sh_direction;
    logic [4:0]  sh_shift_val;
    logic [31:0] sh_data_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_exp;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          run_len = 0;
    int          max_run = 0;
    logic        sends_done;

    shift_cmd_sequencer #(
        .BUSWIDTH(32), .SHIFTWIDTH(5), .CMD_DEPTH(4), .RES_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_rotation(cmd_rotation), .cmd_direction(cmd_direction), .cmd_shift_val(cmd_shift_val),
        .sh_data_in(sh_data_in), .sh_rotation(sh_rotation), .sh_direction(sh_direction),
        .sh_shift_val(sh_shift_val), .sh_data_out(sh_data_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external shifter: registered, one cycle of latency
    function automatic logic [31:0] shift_ref(input logic [31:0] d, input logic rot,
                                              input logic dir, input logic [4:0] sv);
        logic [63:0] dd;
        dd = {d, d};
        if (rot) begin
            if (dir) begin
                dd = dd >> sv;
                return dd[31:0];
            end
            dd = dd << sv;
            return dd[63:32];
        end
        return dir ? (d >> sv) : (d << sv);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_data_out <= '0;
        else        sh_data_out <= shift_ref(sh_data_in, sh_rotation, sh_direction, sh_shift_val);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // command acceptance: record the expected response for each accepted command
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            exp_q.push_back(cur_exp);
            acc_cnt++;
        end
    end

    // result monitor
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            pop_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL res_unexpected: got 0x%08h expected no result", res_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (res_data !== e) begin
                    n_errors++;
                    $display("FAIL res_data: got 0x%08h expected 0x%08h", res_data, e);
                end
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic send(input logic [31:0] d, input logic rot, input logic dir,
                        input logic [4:0] sv, input logic [31:0] exp);
        bit ok;
        ok            = 1'b0;
        cmd_data      = d;
        cmd_rotation  = rot;
        cmd_direction = dir;
        cmd_shift_val = sv;
        cur_exp       = exp;
        cmd_valid     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no cmd_ready expected accept of 0x%08h", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && sends_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_base;
        int pop_base;
        int seen;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_data      = '0;
        cmd_rotation  = 1'b0;
        cmd_direction = 1'b0;
        cmd_shift_val = '0;
        cur_exp       = '0;
        res_ready     = 1'b0;
        sends_done    = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_sh_data",   sh_data_in,         32'd0);
        chk("rst_res_data",  res_data,           32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single command latency
        res_ready     = 1'b1;
        cmd_data      = 32'h0000_00F0;
        cmd_rotation  = 1'b0;
        cmd_direction = 1'b0;
        cmd_shift_val = 5'd4;
        cur_exp       = 32'h0000_0F00;
        cmd_valid     = 1'b1;
        @(negedge clk);
        chk("t1_valid_c0", {31'd0, res_valid}, 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid_c1", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c3", {31'd0, res_valid}, 32'd1);
        wait_idle("t1_idle");
        @(posedge clk);
        #1;

        // 2: back-to-back rotate-right by 8
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h1234_5678 + 32'(i), 1'b1, 1'b1, 5'd8, {8'h78 + 8'(i), 24'h12_3456});
        end
        cmd_valid = 1'b0;
        wait_idle("t2_idle");
        chk("t2_run_len", 32'(max_run), 32'd8);
        @(posedge clk);
        #1;

        // 3 + 4: backpressure, then full-FIFO boundary when draining starts
        res_ready  = 1'b0;
        acc_base   = acc_cnt;
        pop_base   = pop_cnt;
        sends_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send(32'(k + 1), 1'b0, 1'b0, 5'd4, 32'(k + 1) << 4);
                end
                cmd_valid  = 1'b0;
                sends_done = 1'b1;
            end
        join_none
        repeat (12) @(negedge clk);
        chk("t3_accepted",  32'(acc_cnt - acc_base), 32'd6);
        chk("t3_cmd_ready", {31'd0, cmd_ready},      32'd0);
        chk("t3_res_valid", {31'd0, res_valid},      32'd1);
        chk("t3_res_hold",  res_data,                32'h0000_0010);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_full_issue_cycle", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("t4_accept_next",      {31'd0, cmd_ready}, 32'd1);
        wait_idle("t3_idle");
        chk("t3_popped", 32'(pop_cnt - pop_base), 32'd10);
        @(posedge clk);
        #1;

        // 5: reset with 3 queued and 1 in flight
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(32'hA000_0000 + 32'(i), 1'b0, 1'b0, 5'd0, 32'hA000_0000 + 32'(i));
        end
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t5_res_valid", {31'd0, res_valid}, 32'd0);
        chk("t5_busy",      {31'd0, busy},      32'd0);
        chk("t5_sh_data",   sh_data_in,         32'd0);
        chk("t5_res_data",  res_data,           32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        seen      = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        chk("t5_nothing_after", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // 6: shift amount boundaries and logical shifts losing bits
        send(32'h8000_0001, 1'b1, 1'b0, 5'd0,  32'h8000_0001);
        send(32'h8000_0001, 1'b1, 1'b0, 5'd31, 32'hC000_0000);
        send(32'hF000_000F, 1'b0, 1'b1, 5'd4,  32'h0F00_0000);
        send(32'hF000_000F, 1'b0, 1'b0, 5'd4,  32'h0000_00F0);
        cmd_valid = 1'b0;
        wait_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
